branch_resolve_unit: RTL



---
 rtl/branch_pkg.sv | 23 ++
 rtl/branch_resolve_unit_if.sv | 38 +++
 rtl/branch_pht.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants for the branch resolution stage: condition codes,
// flag bit positions and 2-bit predictor counter states.
package branch_pkg;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_OV  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between decode/EX, fetch and the branch resolution stage.
interface branch_resolve_unit_if #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 9
);
    logic [2:0]          flag_wr_en;
    logic [2:0]          flag_wr_data;
    logic                flag_pend;
    logic                br_valid;
    logic                br_ready;
    logic [2:0]          br_cond;
    logic                br_is_reg;
    logic [ADDR_W-1:0]   br_pc;
    logic [OFFSET_W-1:0] br_offset;
    logic [ADDR_W-1:0]   br_reg_target;
    logic                br_pred_taken;
    logic                res_valid;
    logic                res_taken;
    logic [ADDR_W-1:0]   res_target;
    logic                res_mispredict;
    logic [2:0]          flags;
    logic [ADDR_W-1:0]   pred_pc;
    logic                pred_taken_out;

    modport master (
        output flag_wr_en, flag_wr_data, flag_pend, br_valid, br_cond, br_is_reg,
               br_pc, br_offset, br_reg_target, br_pred_taken, pred_pc,
        input  br_ready, res_valid, res_taken, res_target, res_mispredict,
               flags, pred_taken_out
    );

    modport slave (
        input  flag_wr_en, flag_wr_data, flag_pend, br_valid, br_cond, br_is_reg,
               br_pc, br_offset, br_reg_target, br_pred_taken, pred_pc,
        output br_ready, res_valid, res_taken, res_target, res_mispredict,
               flags, pred_taken_out
    );
endinterface

// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating counters, indexed by pc[IDX_W:1].
// Reads are asynchronous and see the pre-update value during an update cycle.
module branch_pht
    import branch_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter int         PHT_DEPTH = 16,
    parameter logic [1:0] CTR_INIT  = CTR_WNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_upd_en,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_rd_pc,
    output logic              o_rd_taken
);
    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [1:0]       r_ctr [PHT_DEPTH];
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_unused_pc;

    assign w_upd_idx   = i_upd_pc[IDX_W:1];
    assign w_rd_idx    = i_rd_pc[IDX_W:1];
    assign w_unused_pc = ^{i_upd_pc[ADDR_W-1:IDX_W+1], i_upd_pc[0],
                           i_rd_pc[ADDR_W-1:IDX_W+1], i_rd_pc[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) r_ctr[i] <= CTR_INIT;
        end else if (i_upd_en) begin
            if (i_upd_taken && r_ctr[w_upd_idx] != CTR_ST)
                r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
            else if (!i_upd_taken && r_ctr[w_upd_idx] != CTR_SNT)
                r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
    end

    assign o_rd_taken = r_ctr[w_rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: N/Z/V flag register with write forwarding,
// condition evaluation, next-PC computation and PHT training.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter int         OFFSET_W  = 9,
    parameter int         PHT_DEPTH = 16,
    parameter logic [1:0] CTR_INIT  = CTR_WNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);
    logic [2:0]        r_flags;
    logic              r_res_valid;
    logic              r_res_taken;
    logic [ADDR_W-1:0] r_res_target;
    logic              r_res_mispredict;

    logic [2:0]        w_eff;
    logic              w_taken;
    logic              w_accept;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_rel;
    logic [ADDR_W-1:0] w_target;

    // Same-cycle flag writes are visible to the branch being evaluated.
    assign w_eff = (bus.flag_wr_en & bus.flag_wr_data) | (~bus.flag_wr_en & r_flags);

    always_comb begin
        w_taken = 1'b0;
        case (bus.br_cond)
            COND_NE:  w_taken = ~w_eff[FLAG_Z];
            COND_EQ:  w_taken =  w_eff[FLAG_Z];
            COND_GT:  w_taken = ~w_eff[FLAG_Z] & ~w_eff[FLAG_N];
            COND_LT:  w_taken =  w_eff[FLAG_N];
            COND_GE:  w_taken =  w_eff[FLAG_Z] | ~w_eff[FLAG_N];
            COND_LE:  w_taken =  w_eff[FLAG_N] |  w_eff[FLAG_Z];
            COND_OV:  w_taken =  w_eff[FLAG_V];
            COND_UNC: w_taken = 1'b1;
            default:  w_taken = 1'b0;
        endcase
    end

    // Offset counts instruction words; shift by one to get a byte displacement.
    assign w_seq     = bus.br_pc + ADDR_W'(2);
    assign w_off_ext = {{(ADDR_W-OFFSET_W){bus.br_offset[OFFSET_W-1]}}, bus.br_offset};
    assign w_rel     = w_seq + {w_off_ext[ADDR_W-2:0], 1'b0};
    assign w_target  = !w_taken      ? w_seq :
                       bus.br_is_reg ? bus.br_reg_target : w_rel;

    assign w_accept = bus.br_valid & ~bus.flag_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags          <= '0;
            r_res_valid      <= 1'b0;
            r_res_taken      <= 1'b0;
            r_res_target     <= '0;
            r_res_mispredict <= 1'b0;
        end else begin
            r_flags     <= w_eff;
            r_res_valid <= w_accept;
            if (w_accept) begin
                r_res_taken      <= w_taken;
                r_res_target     <= w_target;
                r_res_mispredict <= w_taken ^ bus.br_pred_taken;
            end
        end
    end

    branch_pht #(
        .ADDR_W    (ADDR_W),
        .PHT_DEPTH (PHT_DEPTH),
        .CTR_INIT  (CTR_INIT)
    ) u_pht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_upd_en    (w_accept),
        .i_upd_pc    (bus.br_pc),
        .i_upd_taken (w_taken),
        .i_rd_pc     (bus.pred_pc),
        .o_rd_taken  (bus.pred_taken_out)
    );

    assign bus.br_ready       = ~bus.flag_pend;
    assign bus.flags          = r_flags;
    assign bus.res_valid      = r_res_valid;
    assign bus.res_taken      = r_res_taken;
    assign bus.res_target     = r_res_target;
    assign bus.res_mispredict = r_res_mispredict;

endmodule
